// File: rtl/spike_dispatcher.sv
// ---------------------------------------------------------------------------
// spike_dispatcher
//
// Timestep sequencer and spike-packet dispatcher for an N-neuron cluster.
// A free-running IDLE/RUN/CLR state machine emits one `clear` pulse every
// TIMESTEP_CYCLES+1 cycles while enabled. Incoming {origin, destination}
// packets are buffered in a FIFO. While in RUN, the head packet is popped
// once per cycle. Its origin address is then written to the source-address
// lane of the destination neuron, together with a one-cycle valid strobe.
//
// Optional build macro:
//   SPIKE_DISPATCHER_BROADCAST_EN - destination all-ones writes every lane
//                                   and strobes every valid bit. When the
//                                   macro is undefined, all-ones is dropped
//                                   as an out-of-range destination.
//
// Ports:
//   CLK                 in   rising-edge clock
//   RESET               in   asynchronous active-high reset
//   enable              in   run timestep sequencing and dispatch
//   packet_in           in   [2*AW-1:AW] origin, [AW-1:0] destination
//   packet_valid        in   packet_in valid this cycle
//   packet_ready        out  FIFO can accept (not full)
//   clear               out  one-cycle timestep-boundary pulse
//   source_address_out  out  lane k = bits [(k+1)*AW-1 : k*AW]
//   source_valid        out  one-cycle delivery strobe per lane
//   fifo_level          out  current FIFO occupancy
//   timestep_count      out  completed timesteps (wrapping)
//   dropped_count       out  packets with invalid destination (saturating)
// ---------------------------------------------------------------------------
module spike_dispatcher #(
    parameter int NUM_NEURONS     = 10,
    parameter int ADDR_WIDTH      = 12,
    parameter int FIFO_DEPTH      = 8,
    parameter int TIMESTEP_CYCLES = 4
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              enable,
    input  logic [2*ADDR_WIDTH-1:0]           packet_in,
    input  logic                              packet_valid,
    output logic                              packet_ready,
    output logic                              clear,
    output logic [NUM_NEURONS*ADDR_WIDTH-1:0] source_address_out,
    output logic [NUM_NEURONS-1:0]            source_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic [15:0]                       timestep_count,
    output logic [15:0]                       dropped_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH+1);
    localparam int CNT_W   = $clog2(TIMESTEP_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CLR  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Timestep state machine
    // -----------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        clear      = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // Dropping enable wins over reaching the timestep boundary.
                if (!enable) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_W'(TIMESTEP_CYCLES-1)) begin
                    state_next = CLR;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            CLR: begin
                clear      = 1'b1;
                cnt_next   = '0;
                state_next = enable ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Packet FIFO. Read is asynchronous so a packet written at edge N can be
    // dispatched at edge N+1.
    // -----------------------------------------------------------------------
    logic [2*ADDR_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [LEVEL_W-1:0]      level_reg;
    logic                    push, pop;

    assign packet_ready = (level_reg != LEVEL_W'(FIFO_DEPTH));
    assign fifo_level   = level_reg;
    assign push         = packet_valid && packet_ready;
    assign pop          = (state_reg == RUN) && (level_reg != '0);

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= packet_in;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LEVEL_W'(1);
                2'b01:   level_reg <= level_reg - LEVEL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Head decode and lane delivery
    // -----------------------------------------------------------------------
    logic [2*ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0]   head_origin;
    logic [ADDR_WIDTH-1:0]   head_dest;
    logic                    is_bcast;
    logic                    dest_in_range;
    logic                    drop;
    logic [NUM_NEURONS-1:0]  lane_hit;

    assign head        = fifo_mem[rd_ptr_reg];
    assign head_origin = head[2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign head_dest   = head[ADDR_WIDTH-1:0];

`ifdef SPIKE_DISPATCHER_BROADCAST_EN
    assign is_bcast = (head_dest == {ADDR_WIDTH{1'b1}});
`else
    assign is_bcast = 1'b0;
`endif

    assign dest_in_range = (head_dest < ADDR_WIDTH'(NUM_NEURONS));
    assign drop          = pop && !dest_in_range && !is_bcast;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_lane
            assign lane_hit[gi] = pop && (is_bcast || (head_dest == ADDR_WIDTH'(gi)));
        end
    endgenerate

    logic [ADDR_WIDTH-1:0]  lane_addr_reg [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] lane_valid_reg;

    // All-ones on a lane marks "nothing delivered yet".
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lane_valid_reg <= '0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                lane_addr_reg[k] <= '1;
            end
        end else begin
            lane_valid_reg <= lane_hit;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                if (lane_hit[k]) begin
                    lane_addr_reg[k] <= head_origin;
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_out
            assign source_address_out[gi*ADDR_WIDTH +: ADDR_WIDTH] = lane_addr_reg[gi];
        end
    endgenerate
    assign source_valid = lane_valid_reg;

    // -----------------------------------------------------------------------
    // Statistics counters
    // -----------------------------------------------------------------------
    logic [15:0] ts_count_reg, drop_count_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ts_count_reg   <= '0;
            drop_count_reg <= '0;
        end else begin
            if (state_reg == CLR) begin
                ts_count_reg <= ts_count_reg + 16'd1;
            end
            if (drop && (drop_count_reg != 16'hFFFF)) begin
                drop_count_reg <= drop_count_reg + 16'd1;
            end
        end
    end

    assign timestep_count = ts_count_reg;
    assign dropped_count  = drop_count_reg;

endmodule

// File: tb/tb_spike_dispatcher.sv
module tb_spike_dispatcher;

    logic         CLK;
    logic         RESET;
    logic         enable;
    logic [23:0]  packet_in;
    logic         packet_valid;
    logic         packet_ready;
    logic         clear;
    logic [119:0] source_address_out;
    logic [9:0]   source_valid;
    logic [3:0]   fifo_level;
    logic [15:0]  timestep_count;
    logic [15:0]  dropped_count;

    spike_dispatcher #(
        .NUM_NEURONS(10),
        .ADDR_WIDTH(12),
        .FIFO_DEPTH(8),
        .TIMESTEP_CYCLES(4)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .enable(enable),
        .packet_in(packet_in),
        .packet_valid(packet_valid),
        .packet_ready(packet_ready),
        .clear(clear),
        .source_address_out(source_address_out),
        .source_valid(source_valid),
        .fifo_level(fifo_level),
        .timestep_count(timestep_count),
        .dropped_count(dropped_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [9:0]  mask;
        logic [11:0] origin;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   exp_drop  = 0;
    int   max_level = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected response of one accepted packet.
    task automatic exp_push(input logic [11:0] org, input logic [11:0] dst);
        exp_t e;
        if (dst < 12'd10) begin
            e.mask   = 10'd1 << dst;
            e.origin = org;
            exp_q.push_back(e);
`ifdef SPIKE_DISPATCHER_BROADCAST_EN
        end else if (dst == 12'hFFF) begin
            e.mask   = 10'h3FF;
            e.origin = org;
            exp_q.push_back(e);
`endif
        end else begin
            exp_drop++;
        end
    endtask

    // Called #1 after a rising edge; presents one packet over the next edge.
    task automatic push(input logic [11:0] org, input logic [11:0] dst, input bit acc);
        packet_in    = {org, dst};
        packet_valid = 1'b1;
        chk("packet_ready", {31'd0, packet_ready}, {31'd0, acc});
        if (acc) exp_push(org, dst);
        @(posedge CLK);
        #1;
        packet_valid = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_clear", {31'd0, clear}, 32'd0);
        chk("rst_source_valid", {22'd0, source_valid}, 32'd0);
        chk("rst_lanes_all_ones", {31'd0, (source_address_out == {120{1'b1}})}, 32'd1);
        chk("rst_fifo_level", {28'd0, fifo_level}, 32'd0);
        chk("rst_timestep_count", {16'd0, timestep_count}, 32'd0);
        chk("rst_dropped_count", {16'd0, dropped_count}, 32'd0);
        chk("rst_packet_ready", {31'd0, packet_ready}, 32'd1);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected delivery.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RESET && (source_valid != 10'd0)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {22'd0, source_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_mask", {22'd0, source_valid}, {22'd0, e.mask});
                    for (int k = 0; k < 10; k++) begin
                        if (e.mask[k]) begin
                            chk($sformatf("lane%0d_addr", k),
                                {20'd0, source_address_out[k*12 +: 12]}, {20'd0, e.origin});
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        RESET        = 1'b0;
        enable       = 1'b0;
        packet_in    = '0;
        packet_valid = 1'b0;
        #1 RESET = 1'b1;
        #11;
        chk_reset_values();

        // Timestep sequencing: clear after edges 5, 10, 15.
        @(posedge CLK);
        #1;
        RESET  = 1'b0;
        enable = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("clear_edge%0d", k), {31'd0, clear},
                {31'd0, (k == 5 || k == 10 || k == 15)});
        end
        chk("timestep_count_3", {16'd0, timestep_count}, 32'd3);
        chk("idle_lanes_all_ones", {31'd0, (source_address_out == {120{1'b1}})}, 32'd1);
        chk("idle_fifo_level", {28'd0, fifo_level}, 32'd0);

        // Single packet, one-cycle latency.
        push(12'h3F8, 12'd0, 1'b1);
        chk("level_after_push", {28'd0, fifo_level}, 32'd1);
        step(1);
        chk("lat_source_valid", {22'd0, source_valid}, 32'h001);
        chk("lat_lane0", {20'd0, source_address_out[11:0]}, 32'h3F8);
        chk("lat_level", {28'd0, fifo_level}, 32'd0);
        step(1);
        chk("strobe_one_cycle", {22'd0, source_valid}, 32'd0);

        // Fill while disabled: 8 stored, 9th refused.
        enable = 1'b0;
        for (int d = 1; d <= 9; d++) begin
            push(12'(d + 'h100), 12'(d), (d <= 8));
        end
        chk("full_level", {28'd0, fifo_level}, 32'd8);
        chk("full_not_ready", {31'd0, packet_ready}, 32'd0);
        enable = 1'b1;
        step(12);
        chk("drain_level", {28'd0, fifo_level}, 32'd0);
        chk("drain_lane8", {20'd0, source_address_out[8*12 +: 12]}, 32'h108);

        // Invalid destinations.
        push(12'h055, 12'd12, 1'b1);
        push(12'h2AA, 12'hFFF, 1'b1);
        step(6);
        chk("dropped_count", {16'd0, dropped_count}, exp_drop);

        // Reset in the middle of dispatch with 5 packets queued.
        enable = 1'b0;
        step(2);
        for (int d = 2; d <= 6; d++) begin
            push(12'(d + 'h300), 12'(d), 1'b1);
        end
        enable = 1'b1;
        step(2);
        chk("mid_first_strobe", {22'd0, source_valid}, 32'h004);
        @(negedge CLK);
        #1;
        RESET = 1'b1;
        #1;
        chk_reset_values();
        exp_q.delete();
        exp_drop = 0;
        step(2);
        RESET = 1'b0;
        step(10);
        chk("post_reset_level", {28'd0, fifo_level}, 32'd0);

        // Continuous push every cycle in RUN.
        for (int i = 0; i < 12; i++) begin
            push(12'(i + 'h200), 12'(i % 10), 1'b1);
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        end
        step(15);
        chk("stream_backlog_le4", {31'd0, (max_level <= 4)}, 32'd1);
        chk("stream_level", {28'd0, fifo_level}, 32'd0);
        chk("stream_dropped", {16'd0, dropped_count}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/spike_dispatcher.md
Name: spike_dispatcher

Overview:
- Parametrised timestep sequencer plus spike-packet dispatcher for an N-neuron cluster.
- Generates the per-timestep `clear` pulse for the neuron array.
- Buffers incoming {origin, destination} spike packets from the network interface in a FIFO and delivers each origin address to the source-address lane of the destination neuron, with a one-cycle valid strobe.
- Sits between network_interface (packet producer) and the neuron array (clear and source_address consumers).

Parameters:
- NUM_NEURONS, 10, number of neuron lanes driven.
- ADDR_WIDTH, 12, width of neuron/source addresses.
- FIFO_DEPTH, 8, packet buffer entries (power of 2, ≥2).
- TIMESTEP_CYCLES, 4, clock cycles per timestep (≥2).

Ports:
- CLK  in  1  clock, rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- enable  in  1  run timestep sequencing and dispatch.
- packet_in  in  2*ADDR_WIDTH  [2*AW-1:AW] = origin, [AW-1:0] = destination.
- packet_valid  in  1  packet_in valid this cycle.
- packet_ready  out  1  FIFO can accept; high when fifo_level < FIFO_DEPTH.
- clear  out  1  one-cycle timestep-boundary pulse to neurons.
- source_address_out  out  NUM_NEURONS*ADDR_WIDTH  lane k = bits [(k+1)*AW-1 : k*AW]; last origin delivered to neuron k.
- source_valid  out  NUM_NEURONS  one-cycle strobe per lane on delivery.
- fifo_level  out  clog2(FIFO_DEPTH+1)  current occupancy.
- timestep_count  out  16  completed timesteps; wraps 0xFFFF -> 0.
- dropped_count  out  16  packets discarded for an invalid destination; saturates at 0xFFFF.

Behaviour:
- Reset (async, any time including mid-dispatch) values:
  - clear = 0, source_valid = 0, every source_address_out lane = all-ones (unused marker).
  - fifo_level = 0, FIFO pointers = 0, timestep_count = 0, dropped_count = 0.
  - State = IDLE, cycle counter = 0.
- packet_ready is combinational: !(fifo_level == FIFO_DEPTH). It is high during and after reset.
- Push: on a rising edge where packet_valid && packet_ready, write packet_in at the tail. When full, packet_valid is ignored and the packet is not stored; the producer holds it.
- State machine:
  - IDLE: cycle counter held at 0, no clear, no dispatch. enable=1 → RUN.
  - RUN: counter increments each cycle. When counter == TIMESTEP_CYCLES-1: counter → 0, go to CLR. enable=0 → IDLE, counter → 0.
  - CLR: clear=1 for exactly this cycle, timestep_count += 1, no dispatch. Then → RUN, or IDLE if enable=0.
  - Result: clear period = TIMESTEP_CYCLES+1 cycles.
- Dispatch: in RUN with FIFO non-empty, pop the head once per cycle.
  - dest < NUM_NEURONS: source_address_out[dest] ← origin and source_valid[dest] = 1 for one cycle. Other lanes keep their value with strobe 0.
  - Otherwise: dropped_count += 1 (saturating), no lane written.
- Latency: a packet pushed at edge N into an empty FIFO in RUN is dispatched at edge N+1 (outputs visible after N+1).
- Ordering is strictly FIFO.
- Push and pop on the same edge: both occur, fifo_level unchanged. A pop frees space only at the next cycle's ready evaluation.
- Pointers wrap modulo FIFO_DEPTH.
- Pending packets survive IDLE and CLR and are dispatched on return to RUN.

Optional Feature:
- Macro: SPIKE_DISPATCHER_BROADCAST_EN.
- Defined: destination == all-ones is a broadcast. All NUM_NEURONS lanes are written with origin and all source_valid bits strobe together. dropped_count is not incremented.
- Undefined: all-ones is out of range and dropped like any invalid destination.

Test Plan:
- Reset then enable=1, defaults → clear pulses on cycles 5, 10, 15; timestep_count reads 3 after the third pulse; all lanes 0xFFF, fifo_level 0.
- Push {origin=0x3F8, dest=0} at edge N in RUN → at edge N+1, lane 0 = 0x3F8, source_valid = 10'b0000000001 for one cycle, fifo_level back to 0.
- With enable=0, push 9 packets (dest 1..9, origin = dest+0x100) → packet_ready low after the 8th, 9th not stored. Then enable=1 → 8 strobes in push order, lanes 1..8 = 0x101..0x108, none during the clear cycle.
- Push dest=12 and dest=0xFFF (macro undefined) → dropped_count = 2, no source_valid. With macro defined, 0xFFF → all 10 strobes, lanes = origin, dropped_count = 1.
- Assert RESET mid-stream with 5 packets queued → outputs return to reset values immediately; no strobes after release until new pushes.
- Continuous push every cycle in RUN → fifo_level never exceeds TIMESTEP_CYCLES-related backlog of 1 per CLR cycle; all packets delivered in order, none dropped.
